// File: rtl/alu_req_scheduler_if.sv
// Request/response bundle for alu_req_scheduler.
//
// Purpose : groups the per-requester valid/ready/operand signals and the
//           tagged response handshake into one interface.
// Signals : req_valid/req_ready  per-requester handshake (NUM_REQ bits)
//           req_a/req_b          packed 32-bit operands, requester i at [32i+31:32i]
//           req_op               packed 4-bit opcodes, requester i at [4i+3:4i]
//           rsp_valid/rsp_ready  response handshake
//           rsp_id               owning requester index (ID_W bits)
//           rsp_result/rsp_zero  captured ALU result and zero flag
//           rsp_err              illegal-opcode flag, present only when
//                                ALU_SCHED_OPCHECK_EN is defined
// Modports: master = requester/consumer side, slave = scheduler side.
interface alu_req_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_a;
    logic [NUM_REQ*32-1:0] req_b;
    logic [NUM_REQ*4-1:0]  req_op;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [31:0]           rsp_result;
    logic                  rsp_zero;
`ifdef ALU_SCHED_OPCHECK_EN
    logic                  rsp_err;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err
    );
    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err
    );
`else
    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero
    );
    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero
    );
`endif
endinterface

// File: rtl/alu_req_scheduler.sv
// alu_req_scheduler: round-robin sharing of one combinational 32-bit ALU
// between NUM_REQ requesters.
//
// Ports : clk        single clock, rising edge
//         rst_n      synchronous active-low reset
//         bus        alu_req_scheduler_if.slave (requests in, tagged response out)
//         alu_a/b    registered operands to the shared ALU
//         alu_op     registered opcode to the shared ALU
//         alu_result ALU result, captured during EXEC
//         alu_zero   ALU zero flag, captured during EXEC
//         busy       high whenever the scheduler is not IDLE
// Option: ALU_SCHED_OPCHECK_EN adds bus.rsp_err; opcodes above 6 are accepted
//         but replaced by opcode 0 at the ALU and answered with result 0,
//         zero 0, err 1.
module alu_req_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_req_scheduler_if.slave bus,
    output logic [31:0]        alu_a,
    output logic [31:0]        alu_b,
    output logic [3:0]         alu_op,
    input  logic [31:0]        alu_result,
    input  logic               alu_zero,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state;
    state_t          state_next;

    logic [ID_W-1:0] rr_ptr;       // last granted requester
    logic [ID_W-1:0] grant_idx;
    logic            grant_found;
    logic            can_grant;
    logic            grant_en;
    int              cand;
    logic [ID_W-1:0] cand_idx;

    logic [31:0]     sel_a;
    logic [31:0]     sel_b;
    logic [3:0]      sel_op;

    logic [ID_W-1:0] id_p0;
    logic [31:0]     result_p1;
    logic            zero_p1;
`ifdef ALU_SCHED_OPCHECK_EN
    logic            err_p0;
    logic            err_p1;
`endif

    // Round-robin search beginning one past the last granted requester.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand     = (int'(rr_ptr) + k) % NUM_REQ;
            cand_idx = cand[ID_W-1:0];
            if (!grant_found && bus.req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // A grant may only be offered while idle or while the current response
    // is being accepted; reset suppresses any grant in the same cycle.
    assign can_grant = rst_n && ((state == IDLE) || ((state == RESP) && bus.rsp_ready));
    assign grant_en  = can_grant && grant_found;

    always_comb begin
        bus.req_ready = '0;
        if (grant_en) begin
            bus.req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        sel_a  = bus.req_a[int'(grant_idx)*32 +: 32];
        sel_b  = bus.req_b[int'(grant_idx)*32 +: 32];
        sel_op = bus.req_op[int'(grant_idx)*4 +: 4];
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_en) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                state_next = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_next = grant_found ? EXEC : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Stage p0: grant edge latches operands, opcode and owner index.
    // Stage p1: EXEC edge captures the ALU outcome for the response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr    <= ID_W'(NUM_REQ - 1);
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            id_p0     <= '0;
            result_p1 <= '0;
            zero_p1   <= 1'b0;
`ifdef ALU_SCHED_OPCHECK_EN
            err_p0    <= 1'b0;
            err_p1    <= 1'b0;
`endif
        end else begin
            if (grant_en) begin
                alu_a  <= sel_a;
                alu_b  <= sel_b;
                id_p0  <= grant_idx;
                rr_ptr <= grant_idx;
`ifdef ALU_SCHED_OPCHECK_EN
                alu_op <= (sel_op > 4'd6) ? 4'd0 : sel_op;
                err_p0 <= (sel_op > 4'd6);
`else
                alu_op <= sel_op;
`endif
            end
            if (state == EXEC) begin
`ifdef ALU_SCHED_OPCHECK_EN
                result_p1 <= err_p0 ? 32'd0 : alu_result;
                zero_p1   <= err_p0 ? 1'b0 : alu_zero;
                err_p1    <= err_p0;
`else
                result_p1 <= alu_result;
                zero_p1   <= alu_zero;
`endif
            end
        end
    end

    assign bus.rsp_valid  = (state == RESP);
    assign bus.rsp_id     = id_p0;
    assign bus.rsp_result = result_p1;
    assign bus.rsp_zero   = zero_p1;
`ifdef ALU_SCHED_OPCHECK_EN
    assign bus.rsp_err    = err_p1;
`endif
    assign busy           = (state != IDLE);

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Testbench for alu_req_scheduler: directed steps followed by a randomized
// phase checked against a round-robin/queue reference model.
module tb_alu_req_scheduler;
    localparam int N  = 4;
    localparam int IW = 2;

    logic        clk;
    logic        rst_n;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        busy;

    logic        va [N];
    logic [31:0] oa [N];
    logic [31:0] ob [N];
    logic [3:0]  oo [N];
    logic        rsp_rdy;

    int compared   = 0;
    int mismatched = 0;
    int last       = N - 1;

    typedef struct {
        int          id;
        logic [31:0] res;
        logic        zero;
        logic        err;
    } exp_t;
    exp_t q[$];

    alu_req_scheduler_if #(.NUM_REQ(N)) bus ();

    alu_req_scheduler #(.NUM_REQ(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [32:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
        logic [31:0] r;
        case (op)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = a & b;
            4'd3:    r = a | b;
            4'd4:    r = a ^ b;
            4'd5:    r = a << b[4:0];
            4'd6:    r = a >> b[4:0];
            default: r = 32'd0;
        endcase
        return {(r == 32'd0), r};
    endfunction

    // Shared ALU seen by the scheduler
    always_comb begin
        {alu_zero, alu_result} = alu_ref(alu_a, alu_b, alu_op);
    end

    always_comb begin
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = '0;
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]      = va[i];
            bus.req_a[i*32 +: 32] = oa[i];
            bus.req_b[i*32 +: 32] = ob[i];
            bus.req_op[i*4 +: 4]  = oo[i];
        end
        bus.rsp_ready = rsp_rdy;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t expect_of(input int id, input logic [31:0] a,
                                       input logic [31:0] b, input logic [3:0] op);
        exp_t e;
        logic [32:0] zr;
        zr     = alu_ref(a, b, op);
        e.id   = id;
        e.res  = zr[31:0];
        e.zero = zr[32];
        e.err  = 1'b0;
`ifdef ALU_SCHED_OPCHECK_EN
        if (op > 4'd6) begin
            e.res  = 32'd0;
            e.zero = 1'b0;
            e.err  = 1'b1;
        end
`endif
        return e;
    endfunction

    function automatic int rr_pick();
        for (int k = 1; k <= N; k++) begin
            if (va[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic all_idle();
        for (int i = 0; i < N; i++) va[i] = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        all_idle();
        @(posedge clk); #1;
        rst_n = 1'b1;
        last  = N - 1;
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_req_ready"}, 32'(bus.req_ready), 32'd0);
        check({pfx, "_alu_a"}, alu_a, 32'd0);
        check({pfx, "_alu_b"}, alu_b, 32'd0);
        check({pfx, "_alu_op"}, 32'(alu_op), 32'd0);
        check({pfx, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({pfx, "_rsp_id"}, 32'(bus.rsp_id), 32'd0);
        check({pfx, "_rsp_result"}, bus.rsp_result, 32'd0);
        check({pfx, "_rsp_zero"}, 32'(bus.rsp_zero), 32'd0);
        check({pfx, "_busy"}, 32'(busy), 32'd0);
`ifdef ALU_SCHED_OPCHECK_EN
        check({pfx, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
`endif
    endtask

    // Single isolated operation with spec-literal expected result/zero.
    task automatic do_op(input string tag, input int r, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] op,
                         input logic [31:0] exp_res, input logic exp_zero);
        bit got = 0;
        logic [3:0] exp_aluop;
        exp_aluop = op;
`ifdef ALU_SCHED_OPCHECK_EN
        if (op > 4'd6) exp_aluop = 4'd0;
`endif
        oa[r] = a; ob[r] = b; oo[r] = op; va[r] = 1'b1; rsp_rdy = 1'b1;
        for (int t = 0; t < 8 && !got; t++) begin
            @(negedge clk);
            if (bus.req_ready[r]) got = 1;
            @(posedge clk); #1;
        end
        check({tag, "_granted"}, 32'(got), 32'd1);
        va[r] = 1'b0;
        if (got) begin
            @(negedge clk);
            check({tag, "_alu_op"}, 32'(alu_op), 32'(exp_aluop));
            @(posedge clk); #1;
            @(negedge clk);
            check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
            check({tag, "_rsp_id"}, 32'(bus.rsp_id), 32'(r));
            check({tag, "_rsp_result"}, bus.rsp_result, exp_res);
            check({tag, "_rsp_zero"}, 32'(bus.rsp_zero), 32'(exp_zero));
`ifdef ALU_SCHED_OPCHECK_EN
            check({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'(op > 4'd6));
`endif
            @(posedge clk); #1;
        end
    endtask

    task automatic new_ops(input int i);
        oa[i] = $urandom;
        ob[i] = ($urandom_range(0, 3) == 0) ? oa[i] : $urandom;
        oo[i] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                           : 4'($urandom_range(0, 6));
    endtask

    initial begin
        logic [N-1:0] g;
        int           gi;
        exp_t         e;

        rst_n   = 1'b0;
        rsp_rdy = 1'b1;
        for (int i = 0; i < N; i++) begin
            va[i] = 1'b0; oa[i] = '0; ob[i] = '0; oo[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) va[i] = 1'b1;
        @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk); #1;
        all_idle();
        rst_n = 1'b1;

        // Single requester 1, ADD 5 + 7
        oa[1] = 32'd5; ob[1] = 32'd7; oo[1] = 4'd0; va[1] = 1'b1;
        @(negedge clk);
        check("t1_grant", 32'(bus.req_ready), 32'h2);
        @(posedge clk); #1;
        va[1] = 1'b0;
        @(negedge clk);
        check("t1_exec_ready", 32'(bus.req_ready), 32'd0);
        check("t1_exec_busy", 32'(busy), 32'd1);
        check("t1_exec_valid", 32'(bus.rsp_valid), 32'd0);
        check("t1_alu_a", alu_a, 32'd5);
        check("t1_alu_b", alu_b, 32'd7);
        @(posedge clk); #1;
        @(negedge clk);
        check("t1_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("t1_rsp_id", 32'(bus.rsp_id), 32'd1);
        check("t1_rsp_result", bus.rsp_result, 32'd12);
        check("t1_rsp_zero", 32'(bus.rsp_zero), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("t1_idle_valid", 32'(bus.rsp_valid), 32'd0);
        check("t1_idle_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;

        // All requesters valid continuously, rsp_ready high
        do_reset();
        for (int i = 0; i < N; i++) begin
            oa[i] = 32'(i * 10); ob[i] = 32'd1; oo[i] = 4'd0; va[i] = 1'b1;
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c % 2 == 0) check("t2_grant", 32'(bus.req_ready), 32'(1 << ((c / 2) % 4)));
            else            check("t2_nogrant", 32'(bus.req_ready), 32'd0);
            if (c >= 2 && c % 2 == 0) begin
                check("t2_rsp_valid", 32'(bus.rsp_valid), 32'd1);
                check("t2_rsp_id", 32'(bus.rsp_id), 32'((c / 2 - 1) % 4));
                check("t2_rsp_result", bus.rsp_result, 32'(((c / 2 - 1) % 4) * 10 + 1));
            end
            @(posedge clk); #1;
        end

        // SUB equal operands from requester 2 under backpressure
        do_reset();
        rsp_rdy = 1'b0;
        oa[2] = 32'h1234; ob[2] = 32'h1234; oo[2] = 4'd1; va[2] = 1'b1;
        @(negedge clk);
        check("t3_grant", 32'(bus.req_ready), 32'h4);
        @(posedge clk); #1;
        va[2] = 1'b0;
        oa[0] = 32'd3; ob[0] = 32'd4; oo[0] = 4'd0; va[0] = 1'b1;
        oa[3] = 32'd9; ob[3] = 32'd1; oo[3] = 4'd0; va[3] = 1'b1;
        @(negedge clk);
        check("t3_exec_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("t3_hold_valid", 32'(bus.rsp_valid), 32'd1);
            check("t3_hold_id", 32'(bus.rsp_id), 32'd2);
            check("t3_hold_result", bus.rsp_result, 32'd0);
            check("t3_hold_zero", 32'(bus.rsp_zero), 32'd1);
            check("t3_hold_ready", 32'(bus.req_ready), 32'd0);
            @(posedge clk); #1;
        end
        rsp_rdy = 1'b1;
        @(negedge clk);
        check("t3_next_grant", 32'(bus.req_ready), 32'h8);
        @(posedge clk); #1;

        // Shifts and a zero-producing XOR
        do_reset();
        do_op("sll", 0, 32'd1, 32'h25, 4'd5, 32'h20, 1'b0);
        do_op("srl", 3, 32'h8000_0000, 32'd31, 4'd6, 32'd1, 1'b0);
        do_op("xor", 2, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 4'd4, 32'd0, 1'b1);

        // Reset asserted mid-EXEC with requests pending
        do_reset();
        for (int i = 0; i < N; i++) begin
            oa[i] = 32'(i + 100); ob[i] = 32'd2; oo[i] = 4'd3; va[i] = 1'b1;
        end
        @(negedge clk);
        check("t5_grant", 32'(bus.req_ready), 32'h1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("t5_rst_noready", 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_vals("t5_rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_first_grant", 32'(bus.req_ready), 32'h1);
        @(posedge clk); #1;

        // Illegal opcode 4'hF
        do_reset();
`ifdef ALU_SCHED_OPCHECK_EN
        do_op("opF", 1, 32'h55, 32'h66, 4'hF, 32'd0, 1'b0);
`else
        do_op("opF", 1, 32'h55, 32'h66, 4'hF, 32'd0, 1'b1);
`endif

        // Randomized traffic against the round-robin/queue model
        do_reset();
        q.delete();
        for (int i = 0; i < N; i++) begin
            new_ops(i);
            va[i] = 1'($urandom_range(0, 1));
        end
        rsp_rdy = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            g  = bus.req_ready;
            gi = -1;
            for (int i = 0; i < N; i++) if (g[i]) gi = i;
            check("rnd_onehot", 32'($countones(g) <= 1), 32'd1);
            if (bus.rsp_valid && !bus.rsp_ready)
                check("rnd_no_grant_backpressure", 32'(g), 32'd0);
            if ((va[0] || va[1] || va[2] || va[3]) && (!busy || (bus.rsp_valid && bus.rsp_ready)))
                check("rnd_must_grant", 32'(g != 0), 32'd1);
            if (g != 0) begin
                check("rnd_rr_order", 32'(gi), 32'(rr_pick()));
                q.push_back(expect_of(gi, oa[gi], ob[gi], oo[gi]));
                last = gi;
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                check("rnd_rsp_expected", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    check("rnd_rsp_id", 32'(bus.rsp_id), 32'(e.id));
                    check("rnd_rsp_result", bus.rsp_result, e.res);
                    check("rnd_rsp_zero", 32'(bus.rsp_zero), 32'(e.zero));
`ifdef ALU_SCHED_OPCHECK_EN
                    check("rnd_rsp_err", 32'(bus.rsp_err), 32'(e.err));
`endif
                end
            end
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (i == gi) begin
                    va[i] = 1'($urandom_range(0, 1));
                    new_ops(i);
                end else if (!va[i]) begin
                    if ($urandom_range(0, 9) < 4) begin
                        va[i] = 1'b1;
                        new_ops(i);
                    end
                end else if ($urandom_range(0, 19) == 0) begin
                    va[i] = 1'b0;
                end
            end
            rsp_rdy = ($urandom_range(0, 3) != 0);
        end

        // Drain outstanding responses
        all_idle();
        rsp_rdy = 1'b1;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            if (bus.rsp_valid && q.size() != 0) begin
                e = q.pop_front();
                check("drain_rsp_id", 32'(bus.rsp_id), 32'(e.id));
                check("drain_rsp_result", bus.rsp_result, e.res);
                check("drain_rsp_zero", 32'(bus.rsp_zero), 32'(e.zero));
            end
            @(posedge clk); #1;
        end
        check("drain_queue_empty", 32'(q.size()), 32'd0);
        check("drain_idle", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
